// File: rtl/rle_pkg.sv
// Shared definitions for the RLE decompressor: FSM state encoding,
// token field layout and default widths.
package rle_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int PIX_W_DEFAULT  = 8;
    localparam int CNT_W_DEFAULT  = 8;

    // Token layout: pixel value in the low bits, run count directly above it.
    localparam int PIX_OFFSET = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } rleState_t;

    // Bit position of the run-count field for a given pixel width.
    function automatic int cntOffset(input int pixW);
        return PIX_OFFSET + pixW;
    endfunction

    // Full token width for the given field widths.
    function automatic int tokenWidth(input int cntW, input int pixW);
        return cntW + pixW;
    endfunction

endpackage

// File: rtl/rle_addr_counter.sv
// Loadable write-address counter for the RLE decompressor.
// Wraps naturally from all-ones to zero; load has priority over increment.
module rle_addr_counter #(
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Load,
    input  logic [ADDR_W-1:0] LoadValue,
    input  logic              Inc,
    output logic [ADDR_W-1:0] Address
);

    // Address register: load the job base, otherwise step after each write.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Address <= '0;
        end else if (Load) begin
            Address <= LoadValue;
        end else if (Inc) begin
            Address <= Address + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/rle_decompressor.sv
// Run-length decompressor: accepts {count, pixel} tokens and writes
// TotalWords pixels to consecutive RAM addresses starting at BaseAddress.
// Optional feature: define RLE_WR_STALL_EN to add a WrReady back-pressure
// input; without it every write is accepted immediately.
module rle_decompressor
    import rle_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int PIX_W  = PIX_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic                   Start,
    input  logic [ADDR_W-1:0]      BaseAddress,
    input  logic [ADDR_W-1:0]      TotalWords,
    input  logic                   InValid,
    input  logic [CNT_W+PIX_W-1:0] InData,
`ifdef RLE_WR_STALL_EN
    input  logic                   WrReady,
`endif
    output logic                   InReady,
    output logic [ADDR_W-1:0]      AddressInDecompressed,
    output logic [PIX_W-1:0]       WrData,
    output logic                   WrEn,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Error
);

    localparam int TOKEN_W = tokenWidth(CNT_W, PIX_W);
    localparam int CNT_LSB = cntOffset(PIX_W);
    localparam int CMP_W   = (CNT_W > ADDR_W) ? CNT_W : ADDR_W;

    rleState_t         state;
    rleState_t         nextState;
    logic [ADDR_W-1:0] remaining;   // pixels still owed to the job
    logic [CNT_W-1:0]  runLeft;     // pixels still owed to the current run

    logic              wrAdvance;
    logic              startJob;
    logic              tokenAccept;
    logic              runOverrun;
    logic              expandStep;
    logic              runLast;
    logic              lastPixel;
    logic [CNT_W-1:0]  tokenCount;
    logic [PIX_W-1:0]  tokenPixel;

`ifdef RLE_WR_STALL_EN
    assign wrAdvance = WrReady;
`else
    assign wrAdvance = 1'b1;
`endif

    assign tokenCount  = InData[TOKEN_W-1:CNT_LSB];
    assign tokenPixel  = InData[PIX_OFFSET +: PIX_W];
    assign startJob    = (state == IDLE) && Start;
    assign tokenAccept = (state == FETCH) && InValid;
    // A run longer than what the job still owes is clipped and flagged.
    assign runOverrun  = CMP_W'(tokenCount) > CMP_W'(remaining);
    assign expandStep  = (state == EXPAND) && wrAdvance;
    assign runLast     = (runLeft == CNT_W'(1));
    assign lastPixel   = (remaining == ADDR_W'(1));

    assign InReady = (state == FETCH);
    assign WrEn    = (state == EXPAND);
    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);

    // State register.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    // NOTE: nextState gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    nextState = (TotalWords == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (InValid && (tokenCount != '0)) begin
                    nextState = EXPAND;
                end
            end
            EXPAND: begin
                if (wrAdvance && runLast) begin
                    nextState = lastPixel ? DONE : FETCH;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Job/run counters, latched pixel value and sticky overrun flag.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            remaining <= '0;
            runLeft   <= '0;
            WrData    <= '0;
            Error     <= 1'b0;
        end else begin
            if (startJob) begin
                remaining <= TotalWords;
                Error     <= 1'b0;
            end
            if (tokenAccept && (tokenCount != '0)) begin
                WrData  <= tokenPixel;
                runLeft <= runOverrun ? CNT_W'(remaining) : tokenCount;
                if (runOverrun) begin
                    Error <= 1'b1;
                end
            end
            if (expandStep) begin
                remaining <= remaining - ADDR_W'(1);
                runLeft   <= runLeft - CNT_W'(1);
            end
        end
    end

    rle_addr_counter #(
        .ADDR_W (ADDR_W)
    ) uAddrCounter (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .Load      (startJob),
        .LoadValue (BaseAddress),
        .Inc       (expandStep),
        .Address   (AddressInDecompressed)
    );

endmodule
